// File: rtl/rv_pkg.sv
// Shared RV32I encoding constants and enums for the instruction loader and control decoder.
package rv_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    typedef enum logic [1:0] {
        K_R     = 2'd0,
        K_LOAD  = 2'd1,
        K_STORE = 2'd2,
        K_BEQ   = 2'd3
    } kind_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_RANGE = 2'd1,
        ERR_ODD   = 2'd2
    } err_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FULL = 2'd2
    } state_e;

endpackage

// File: rtl/rv_inst_encode.sv
// Combinational RV32I field-to-word encoder for R/LOAD/STORE/BEQ; zero latency, no flow control.
// valid=0 flags an immediate the format cannot represent, with the reason on code.
module rv_inst_encode
    import rv_pkg::*;
(
    input  kind_e       kind,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [12:0] imm,
    output logic [31:0] word,
    output logic        valid,
    output err_e        code
);

    always_comb begin
        word  = 32'd0;
        valid = 1'b1;
        code  = ERR_NONE;
        unique case (kind)
            K_R: begin
                word = {funct7, rs2, rs1, funct3, rd, OP_R};
            end
            K_LOAD: begin
                word = {imm[11:0], rs1, funct3, rd, OP_LOAD};
                if (imm[12] != imm[11]) begin
                    valid = 1'b0;
                    code  = ERR_RANGE;
                end
            end
            K_STORE: begin
                word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
                if (imm[12] != imm[11]) begin
                    valid = 1'b0;
                    code  = ERR_RANGE;
                end
            end
            K_BEQ: begin
                // Branch offsets are halfword multiples; bit 0 is implied and must be zero.
                word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BEQ};
                if (imm[0]) begin
                    valid = 1'b0;
                    code  = ERR_ODD;
                end
            end
            default: begin
                valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/rv_inst_encoder_loader.sv
// Encodes field bundles into RV32I words and writes them sequentially into instruction memory.
// Write appears one cycle after accept; in_ready is high only while a session is running and not full.
module rv_inst_encoder_loader
    import rv_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        kind,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [12:0]       imm,
    output logic              mem_we,
    output logic [ADDR_W+1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    state_e            state;
    logic [ADDR_W-1:0] ptr;
    logic [31:0]       enc_word;
    logic              enc_ok;
    err_e              enc_code;
    logic              accept;

    rv_inst_encode u_encode (
        .kind   (kind_e'(kind)),
        .rd     (rd),
        .rs1    (rs1),
        .rs2    (rs2),
        .funct3 (funct3),
        .funct7 (funct7),
        .imm    (imm),
        .word   (enc_word),
        .valid  (enc_ok),
        .code   (enc_code)
    );

    assign in_ready = (state == S_RUN);
    assign accept   = in_valid && in_ready && !start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ptr       <= '0;
            count     <= '0;
            full      <= 1'b0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            if (start) begin
                state    <= S_RUN;
                ptr      <= '0;
                count    <= '0;
                full     <= 1'b0;
                err      <= 1'b0;
                err_code <= ERR_NONE;
            end else begin
                if (accept) begin
                    if (enc_ok) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= {ptr, 2'b00};
                        mem_wdata <= enc_word;
                        count     <= count + 1'b1;
                        // Pointer parks on the last slot so it never steps past DEPTH-1.
                        if (count + 1'b1 == DEPTH_W) begin
                            full  <= 1'b1;
                            state <= S_FULL;
                        end else begin
                            ptr <= ptr + 1'b1;
                        end
                    end else begin
                        err      <= 1'b1;
                        err_code <= enc_code;
                    end
                end
                // Later assignment overrides the FULL transition when finish coincides.
                if (finish && state != S_IDLE) begin
                    state <= S_IDLE;
                    done  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/rv_inst_encoder_loader.md
Name: rv_inst_encoder_loader

Overview:
- Inverse of the opcode control decoder: takes RV32I instruction fields for the four supported formats (R-type, load, store, beq) and encodes each into a 32-bit word.
- Writes the encoded words sequentially into instruction memory, so test programs can be loaded before the core runs.
- Sits between a host/testbench field stream (valid/ready) and the instruction-memory write port.
- Output opcodes are exactly those the control decoder recognises.

Parameters:
ADDR_W, 10, word-address width of instruction memory
DEPTH, 1024, number of words that may be loaded before full (must be ≤ 2**ADDR_W)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  pulse: begin a new load session at word 0
finish  input  1  pulse: end the current session
in_valid  input  1  field bundle valid
in_ready  output  1  block can accept a bundle
kind  input  2  format: 0=R, 1=LOAD, 2=STORE, 3=BEQ
rd  input  5  destination register
rs1  input  5  source register 1
rs2  input  5  source register 2
funct3  input  3  funct3 field
funct7  input  7  funct7 field (R only)
imm  input  13  signed immediate (I/S use bits 11:0; BEQ uses 12:1)
mem_we  output  1  instruction-memory write strobe
mem_addr  output  ADDR_W+2  byte address, low 2 bits always 0
mem_wdata  output  32  encoded instruction
count  output  ADDR_W+1  words written this session
full  output  1  DEPTH words written
done  output  1  one-cycle pulse on session end
err  output  1  sticky error since start
err_code  output  2  last error: 0=none, 1=RANGE, 2=ODD

Behaviour:
- Reset, asynchronous on rst_n low, effective mid-operation:
  - State goes to IDLE.
  - All outputs and pointers are 0.
- FSM states: IDLE, RUN, FULL.
- in_ready:
  - 1 only in RUN.
  - Combinational from state; never depends on in_valid.
- start:
  - Effective from any state, and has priority over finish and in_valid.
  - Next state is RUN; ptr, count, full, err and err_code are cleared.
  - A bundle presented in the same cycle as start is not accepted.
- Accept occurs when in_valid && in_ready.
- Encoding is combinational from the fields and registered. On a valid accept in cycle N, in cycle N+1:
  - mem_we=1
  - mem_addr={ptr,2'b00}
  - mem_wdata=encoded word
  - ptr and count advance by 1
- Field layouts:
  - R: {funct7, rs2, rs1, funct3, rd, 0110011}
  - LOAD: {imm[11:0], rs1, funct3, rd, 0000011}
  - STORE: {imm[11:5], rs2, rs1, funct3, imm[4:0], 0100011}
  - BEQ: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 1100011}
- Validation, applied at accept:
  - RANGE: LOAD/STORE with imm[12] != imm[11] (value outside the 12-bit signed range).
  - ODD: BEQ with imm[0]=1.
  - R ignores imm; LOAD and BEQ ignore the unused register fields.
- On an invalid bundle:
  - The bundle is consumed and dropped: no mem_we, ptr unchanged.
  - err is set (sticky) and err_code latches the code.
- mem_we is 0 in every cycle without a valid accept in the prior cycle; mem_addr and mem_wdata hold their last values.
- Full:
  - The accept that makes count reach DEPTH moves the FSM to FULL.
  - full=1 and in_ready=0 from the next cycle.
  - full stays set until start or reset.
- finish:
  - In RUN or FULL: next state IDLE, done=1 for one cycle.
  - In IDLE: ignored, no done.
  - If finish coincides with an accept, the bundle is still written and the transition still occurs.
- Wrap-around cannot occur, because ptr never exceeds DEPTH-1.

Decomposition:
- Shared package rv_pkg:
  - Opcode constants (OP_R=0110011, OP_LOAD=0000011, OP_STORE=0100011, OP_BEQ=1100011), also used by the control decoder.
  - kind enum.
  - err_code enum.
  - FSM state enum.
- One sub-module, rv_inst_encode: purely combinational.
  - Inputs: kind and the fields.
  - Outputs: 32-bit word, valid, err_code.
  - Reusable by the bench as a golden model and by a future disassembler check.

Test Plan:
1. start, then R add x3,x1,x2 (rd=3, rs1=1, rs2=2, f3=0, f7=0) -> next cycle mem_we=1, mem_addr=0x000, mem_wdata=0x002081B3, count=1.
2. lw x5,8(x2) (kind=1, rd=5, rs1=2, f3=2, imm=8), then sw x5,-4(x2) (kind=2, rs2=5, rs1=2, f3=2, imm=-4) -> 0x00812283 at addr 0x000, then 0xFE512E23 at addr 0x004.
3. beq x1,x2,-8 (kind=3, rs1=1, rs2=2, f3=0, imm=-8) -> 0xFE208CE3. Then beq with imm=3 -> no mem_we, err=1, err_code=2, count unchanged. Then lw with imm=2048 -> err_code=1.
4. DEPTH=4 override, in_valid held high -> four writes at addrs 0, 4, 8, 0xC; full=1 and in_ready=0 after the 4th; 5th bundle never accepted. start -> full=0, count=0, next write at addr 0.
5. finish in the same cycle as an accept -> word written, done pulses once, state IDLE, in_ready=0. A second finish in IDLE -> no done.
6. rst_n low for 1 cycle mid-stream, asynchronously between clock edges -> mem_we, count, err, in_ready go to 0 immediately. After release, bundles are ignored until start.
